symbol_stream_gen: RTL and testbench
====================================

# symbol_stream_gen

Parametrised test-symbol source for the soft associative memory benches and on-chip self-test. It holds a programmable table of 2^DEPTH_LOG2 stored patterns of SYM_W bits and emits one pattern per accepted transfer, with the pattern chosen in one of three modes: random via a seedable 16-bit LFSR, sequential, or fixed. It can optionally flip one bit per symbol to present noisy probes to the memory. The output uses a valid/ready handshake so the downstream memory can stall the stream.

## Interface
- SYM_W, 8: symbol width; power of 2, 2..128.
- DEPTH_LOG2, 2: log2 of table depth; DEPTH_LOG2 + log2(SYM_W) <= 8.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- clk  in  1  clock; all logic on posedge.
- rstb  in  1  asynchronous active-low reset.
- en  in  1  generation enable.
- mode  in  2  00 random, 01 sequential, 10 fixed, 11 treated as random.
- fix_idx  in  DEPTH_LOG2  table index used in fixed mode.
- noise_thresh  in  8  flip probability numerator /256; 0 disables noise.
- wr_en  in  1  table write strobe.
- wr_addr  in  DEPTH_LOG2  table write index.
- wr_data  in  SYM_W  table write data.
- seed_load  in  1  load LFSR from seed_val.
- seed_val  in  16  new LFSR state; 0 is loaded as 16'h0001.
- out_ready  in  1  downstream accepts symbol.
- out_valid  out  1  symbol/sym_idx/sym_noisy valid.
- symbol  out  SYM_W  emitted pattern.
- sym_idx  out  DEPTH_LOG2  table index the symbol came from.
- sym_noisy  out  1  a bit was flipped in this symbol.

## Operation
- Reset: out_valid=0, symbol=0, sym_idx=0, sym_noisy=0, LFSR=SEED, seq_ptr=0. Table entry k bit j resets to 1 iff popcount(j & k) is even. For SYM_W=8 this gives entry 0=0xFF, 1=0x55, 2=0x33, 3=0x99.
- LFSR: Fibonacci, 16 bits. next = {s[14:0], s[15]^s[13]^s[12]^s[10]}. It advances only on a produce cycle.
- Produce condition: en && (!out_valid || out_ready).
- On a produce cycle, using the current LFSR state s:
  - idx: random uses s[DEPTH_LOG2-1:0]; sequential uses seq_ptr, and seq_ptr then increments and wraps from 2^DEPTH_LOG2-1 to 0; fixed uses fix_idx.
  - flip = (s[15:8] < noise_thresh), unsigned compare.
  - pos = s[DEPTH_LOG2+log2(SYM_W)-1 : DEPTH_LOG2].
  - Registered outputs: symbol = table[idx] ^ (flip << pos), sym_idx = idx, sym_noisy = flip, out_valid = 1.
- If there is no produce cycle and out_valid && out_ready, out_valid <= 0; symbol, sym_idx and sym_noisy hold their values.
- If out_valid && !out_ready, all outputs are held stable regardless of en, mode, table writes or seed load.
- seq_ptr advances only on sequential-mode produce cycles. A mode change does not reset it.
- Table write: on wr_en, table[wr_addr] <= wr_data at the clock edge. A produce in the same cycle from the same index reads the old contents.
- Seed load: LFSR <= (seed_val==0 ? 16'h0001 : seed_val). This takes priority over advance. A produce in the same cycle still uses the old state s.
- Reset asserted mid-stream clears outputs and LFSR immediately (asynchronous). The table returns to its reset contents.

## Timing
- Latency is 1 cycle: a produce condition at edge N gives out_valid=1 with the new symbol after edge N.
- Throughput is 1 symbol/cycle while en=1 and out_ready=1.
- With en=0 and out_ready=1, out_valid drops 1 cycle after the last transfer.
- Table write is visible to produces from the next cycle.
- Seed load is visible to produces from the next cycle.
- Reset release: the first produce can occur on the first edge with rstb=1.

## Test plan
- Reset defaults: hold rstb=0, then release with en=0. Expect all outputs 0. Fixed mode, fix_idx=0..3 one per cycle, en=1, ready=1, noise 0: symbols 0xFF, 0x55, 0x33, 0x99.
- Random sequence: seed_load with seed_val=0x0001, then mode=00, en=1, ready=1, noise 0. Expect symbols 0x55, 0x33, 0xFF, 0xFF with sym_idx 1, 2, 0, 0.
- Noise: seed_val=0x0100, fixed idx 0, noise_thresh=255, one produce. Expect symbol 0xFE, sym_noisy=1. Same setup with noise_thresh=1: symbol 0xFF, sym_noisy=0.
- Backpressure and sequential wrap: mode=01, ready toggled 1,0,0,1, run 6 transfers. Each symbol is held stable while ready=0. Accepted sym_idx sequence is 0,1,2,3,0,1 with no skips or duplicates.
- Table write collision: write 0xA5 to entry 2 in the same cycle as a fixed idx 2 produce. Expect 0x33, then 0xA5 on the next produce.
- Seed zero and async reset: seed_val=0 loads 0x0001, so the random run matches scenario 2. Pulsing rstb low mid-stream between edges clears out_valid immediately. Table entry 2 returns to 0x33.

Source files
------------

// File: rtl/symbol_stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : symbol_stream_gen_if
// Description : Valid/ready symbol stream carrying pattern, index and noise flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface symbol_stream_gen_if #(
    parameter int SYM_W      = 8,
    parameter int DEPTH_LOG2 = 2
);
    logic                  out_valid;
    logic                  out_ready;
    logic [SYM_W-1:0]      symbol;
    logic [DEPTH_LOG2-1:0] sym_idx;
    logic                  sym_noisy;

    modport master (
        output out_valid,
        output symbol,
        output sym_idx,
        output sym_noisy,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  symbol,
        input  sym_idx,
        input  sym_noisy,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/symbol_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : symbol_stream_gen
// Description : Table-driven test-symbol source (random/sequential/fixed pick,
//               optional single-bit noise) behind a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module symbol_stream_gen #(
    parameter int          SYM_W      = 8,
    parameter int          DEPTH_LOG2 = 2,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  wire logic                  clk,
    input  wire logic                  rstb,
    input  wire logic                  en,
    input  wire logic [1:0]            mode,
    input  wire logic [DEPTH_LOG2-1:0] fix_idx,
    input  wire logic [7:0]            noise_thresh,
    input  wire logic                  wr_en,
    input  wire logic [DEPTH_LOG2-1:0] wr_addr,
    input  wire logic [SYM_W-1:0]      wr_data,
    input  wire logic                  seed_load,
    input  wire logic [15:0]           seed_val,
    symbol_stream_gen_if.master        out_if
);

    localparam int          c_DEPTH    = 1 << DEPTH_LOG2;
    localparam int          c_POS_W    = $clog2(SYM_W);
    localparam logic [1:0]  c_MODE_SEQ = 2'b01;
    localparam logic [1:0]  c_MODE_FIX = 2'b10;
    localparam logic [15:0] c_SEED_NZ  = 16'h0001;

    // Walsh-like reset pattern: bit j of entry k set when popcount(j & k) is even.
    function automatic logic [SYM_W-1:0] f_reset_entry(input int unsigned k);
        logic [SYM_W-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < SYM_W; j++) begin
            v[j] = ~^(j & k);
        end
        return v;
    endfunction

    logic [SYM_W-1:0]      table_q [c_DEPTH];
    logic [SYM_W-1:0]      table_d [c_DEPTH];
    logic [15:0]           lfsr_q,      lfsr_d;
    logic [DEPTH_LOG2-1:0] seq_ptr_q,   seq_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [SYM_W-1:0]      symbol_q,    symbol_d;
    logic [DEPTH_LOG2-1:0] sym_idx_q,   sym_idx_d;
    logic                  sym_noisy_q, sym_noisy_d;

    logic                  w_produce;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_flip;
    logic [c_POS_W-1:0]    w_pos;
    logic [SYM_W-1:0]      w_flip_mask;
    logic [15:0]           w_lfsr_step;

    assign w_produce   = en && (!out_valid_q || out_if.out_ready);
    assign w_flip      = (lfsr_q[15:8] < noise_thresh);
    assign w_pos       = lfsr_q[DEPTH_LOG2 +: c_POS_W];
    assign w_flip_mask = {{(SYM_W-1){1'b0}}, w_flip} << w_pos;
    assign w_lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        case (mode)
            c_MODE_SEQ: w_idx = seq_ptr_q;
            c_MODE_FIX: w_idx = fix_idx;
            default:    w_idx = lfsr_q[DEPTH_LOG2-1:0];
        endcase
    end

    // Table write lands at the edge, so a same-cycle produce reads old contents.
    always_comb begin
        for (int k = 0; k < c_DEPTH; k++) begin
            table_d[k] = table_q[k];
        end
        if (wr_en) begin
            table_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        symbol_d    = symbol_q;
        sym_idx_d   = sym_idx_q;
        sym_noisy_d = sym_noisy_q;
        seq_ptr_d   = seq_ptr_q;
        lfsr_d      = lfsr_q;

        if (w_produce) begin
            out_valid_d = 1'b1;
            symbol_d    = table_q[w_idx] ^ w_flip_mask;
            sym_idx_d   = w_idx;
            sym_noisy_d = w_flip;
            lfsr_d      = w_lfsr_step;
            if (mode == c_MODE_SEQ) begin
                seq_ptr_d = seq_ptr_q + DEPTH_LOG2'(1);
            end
        end else if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Seed load overrides the advance; the produce above still used the old state.
        if (seed_load) begin
            lfsr_d = (seed_val == 16'h0000) ? c_SEED_NZ : seed_val;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid_q <= 1'b0;
            symbol_q    <= '0;
            sym_idx_q   <= '0;
            sym_noisy_q <= 1'b0;
            seq_ptr_q   <= '0;
            lfsr_q      <= SEED;
            for (int k = 0; k < c_DEPTH; k++) begin
                table_q[k] <= f_reset_entry(k);
            end
        end else begin
            out_valid_q <= out_valid_d;
            symbol_q    <= symbol_d;
            sym_idx_q   <= sym_idx_d;
            sym_noisy_q <= sym_noisy_d;
            seq_ptr_q   <= seq_ptr_d;
            lfsr_q      <= lfsr_d;
            for (int k = 0; k < c_DEPTH; k++) begin
                table_q[k] <= table_d[k];
            end
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.symbol    = symbol_q;
    assign out_if.sym_idx   = sym_idx_q;
    assign out_if.sym_noisy = sym_noisy_q;

endmodule
`default_nettype wire

// File: tb/tb_symbol_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_symbol_stream_gen
// Description : Directed + randomized bench for symbol_stream_gen against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_symbol_stream_gen;

    localparam int          SYM_W      = 8;
    localparam int          DEPTH_LOG2 = 2;
    localparam int          DEPTH      = 4;
    localparam logic [15:0] SEED       = 16'hACE1;

    logic                  clk          = 1'b0;
    logic                  rstb         = 1'b0;
    logic                  en           = 1'b0;
    logic [1:0]            mode         = 2'b00;
    logic [DEPTH_LOG2-1:0] fix_idx      = '0;
    logic [7:0]            noise_thresh = 8'd0;
    logic                  wr_en        = 1'b0;
    logic [DEPTH_LOG2-1:0] wr_addr      = '0;
    logic [SYM_W-1:0]      wr_data      = '0;
    logic                  seed_load    = 1'b0;
    logic [15:0]           seed_val     = 16'h0000;

    symbol_stream_gen_if #(.SYM_W(SYM_W), .DEPTH_LOG2(DEPTH_LOG2)) sif ();

    symbol_stream_gen #(
        .SYM_W      (SYM_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .SEED       (SEED)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .en           (en),
        .mode         (mode),
        .fix_idx      (fix_idx),
        .noise_thresh (noise_thresh),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .seed_load    (seed_load),
        .seed_val     (seed_val),
        .out_if       (sif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [SYM_W-1:0] m_tab [DEPTH];
    logic [15:0]      m_lfsr;
    int               m_seq;
    logic             m_valid;
    logic [SYM_W-1:0] m_sym;
    logic [DEPTH_LOG2-1:0] m_idx;
    logic             m_noisy;

    logic [7:0] exp_fixed [4] = '{8'hFF, 8'h55, 8'h33, 8'h99};
    logic [7:0] exp_rnd   [4] = '{8'h55, 8'h33, 8'hFF, 8'hFF};
    int         exp_ridx  [4] = '{1, 2, 0, 0};
    int         exp_seq   [6] = '{0, 1, 2, 3, 0, 1};
    bit         rdy_pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int unsigned v;
        int unsigned fb;
        v  = s;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v << 1) | fb) & 32'hFFFF);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++)
            for (int j = 0; j < SYM_W; j++)
                m_tab[k][j] = (($countones(j & k) % 2) == 0);
        m_lfsr  = SEED;
        m_seq   = 0;
        m_valid = 1'b0;
        m_sym   = '0;
        m_idx   = '0;
        m_noisy = 1'b0;
    endtask

    // Applies one clock edge worth of behaviour using the inputs presently driven.
    task automatic model_edge();
        bit produce;
        int idx;
        int pos;
        bit flip;
        produce = en && (!m_valid || sif.out_ready);
        if (produce) begin
            if (mode == 2'b01) begin
                idx   = m_seq;
                m_seq = (m_seq + 1) % DEPTH;
            end else if (mode == 2'b10) begin
                idx = int'(fix_idx);
            end else begin
                idx = int'(m_lfsr) % DEPTH;
            end
            flip    = (int'(m_lfsr) / 256) < int'(noise_thresh);
            pos     = (int'(m_lfsr) / DEPTH) % SYM_W;
            m_sym   = m_tab[idx] ^ (flip ? (SYM_W'(1) << pos) : SYM_W'(0));
            m_idx   = DEPTH_LOG2'(idx);
            m_noisy = flip;
            m_valid = 1'b1;
        end else if (m_valid && sif.out_ready) begin
            m_valid = 1'b0;
        end
        if (wr_en) m_tab[wr_addr] = wr_data;
        if (seed_load)    m_lfsr = (seed_val == 16'h0000) ? 16'h0001 : seed_val;
        else if (produce) m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic check_outputs();
        chk("out_valid", sif.out_valid, m_valid);
        chk("symbol",    sif.symbol,    m_sym);
        chk("sym_idx",   sif.sym_idx,   m_idx);
        chk("sym_noisy", sif.sym_noisy, m_noisy);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        int acc [$];
        sif.out_ready = 1'b1;
        model_reset();

        // Reset defaults
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rstb = 1'b1;
        tick();

        // Fixed mode walks the reset table
        mode = 2'b10; en = 1'b1; noise_thresh = 8'd0;
        for (int i = 0; i < 4; i++) begin
            fix_idx = DEPTH_LOG2'(i);
            tick();
            chk("fixed_symbol", sif.symbol, exp_fixed[i]);
        end

        // Random sequence from seed 1
        en = 1'b0; seed_load = 1'b1; seed_val = 16'h0001;
        tick();
        seed_load = 1'b0; mode = 2'b00; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rand_symbol", sif.symbol, exp_rnd[i]);
            chk("rand_idx",    sif.sym_idx, exp_ridx[i]);
        end

        // Noise at bit 0, then threshold just below the compare
        en = 1'b0; seed_load = 1'b1; seed_val = 16'h0100;
        tick();
        seed_load = 1'b0; mode = 2'b10; fix_idx = '0; noise_thresh = 8'd255; en = 1'b1;
        tick();
        chk("noise_symbol", sif.symbol, 8'hFE);
        chk("noise_flag",   sif.sym_noisy, 1'b1);
        en = 1'b0; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; noise_thresh = 8'd1; en = 1'b1;
        tick();
        chk("quiet_symbol", sif.symbol, 8'hFF);
        chk("quiet_flag",   sif.sym_noisy, 1'b0);
        noise_thresh = 8'd0; en = 1'b0;
        tick();

        // Sequential mode under backpressure
        mode = 2'b01; en = 1'b1;
        for (int cyc = 0; cyc < 40 && acc.size() < 6; cyc++) begin
            sif.out_ready = rdy_pat[cyc % 4];
            if (sif.out_valid && sif.out_ready) acc.push_back(int'(sif.sym_idx));
            tick();
        end
        chk("bp_accept_count", acc.size(), 6);
        for (int i = 0; i < acc.size() && i < 6; i++) chk("bp_seq_idx", acc[i], exp_seq[i]);
        sif.out_ready = 1'b1; en = 1'b0;
        tick();

        // Write collides with a fixed-mode read of the same entry
        mode = 2'b10; fix_idx = 2'd2; en = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5;
        tick();
        chk("collide_old", sif.symbol, 8'h33);
        wr_en = 1'b0;
        tick();
        chk("collide_new", sif.symbol, 8'hA5);

        // Asynchronous reset between edges
        mode = 2'b00;
        repeat (3) tick();
        rstb = 1'b0;
        #1;
        model_reset();
        chk("async_valid", sif.out_valid, 1'b0);
        check_outputs();
        #1;
        rstb = 1'b1;
        mode = 2'b10; fix_idx = 2'd2;
        tick();
        chk("reset_entry2", sif.symbol, 8'h33);

        // Zero seed substitutes 0x0001
        en = 1'b0; seed_load = 1'b1; seed_val = 16'h0000;
        tick();
        seed_load = 1'b0; mode = 2'b00; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("seed0_symbol", sif.symbol, exp_rnd[i]);
            chk("seed0_idx",    sif.sym_idx, exp_ridx[i]);
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            en            = ($urandom % 4) != 0;
            sif.out_ready = ($urandom % 3) != 0;
            mode          = 2'($urandom);
            fix_idx       = DEPTH_LOG2'($urandom);
            noise_thresh  = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom);
            wr_en         = ($urandom % 8) == 0;
            wr_addr       = DEPTH_LOG2'($urandom);
            wr_data       = SYM_W'($urandom);
            seed_load     = ($urandom % 16) == 0;
            seed_val      = (($urandom % 4) == 0) ? 16'h0000 : 16'($urandom);
            tick();
        end
        en = 1'b0; wr_en = 1'b0; seed_load = 1'b0; sif.out_ready = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
